fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the decode stage.
- Reads two consecutive bytes from byte-wide program memory at PC, assembles the big-endian 16-bit opcode, and presents it to decode with a valid/ready handshake.
- Owns the program counter: sequential advance, skip (SE/SNE-style +4), and absolute load (JP/CALL/RET targets) supplied by execute at instruction retirement.

Parameters:
- ADDR_W, 12, program counter and memory address width.
- RESET_PC, 12'h200, PC value after reset (CHIP-8 program start).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- mem_addr  output  ADDR_W  byte address to program memory.
- mem_rd_en  output  1  read strobe; memory returns data one cycle later.
- mem_rdata  input  8  read data, valid the cycle after mem_rd_en=1.
- instruction  output  16  assembled opcode, {byte@pc, byte@pc+1}.
- instr_valid  output  1  instruction is stable and available.
- instr_ready  input  1  consumer accepts; transfer when instr_valid & instr_ready.
- pc  output  ADDR_W  address of the instruction currently held/being fetched.
- pc_load  input  1  on transfer, next PC = pc_load_addr.
- pc_load_addr  input  ADDR_W  absolute target for pc_load.
- pc_skip  input  1  on transfer, next PC = pc + 4.

Behaviour:
- Reset (rst=1 at clock edge): pc=RESET_PC, instruction=16'h0000, instr_valid=0, mem_rd_en=0, mem_addr=RESET_PC, internal hi-byte latch=0, state=S_START. Reset overrides everything, including mid-fetch and a pending transfer.
- All outputs are registered.
- States:
  - S_START: one idle cycle. Register mem_addr=pc, mem_rd_en=1. Go to S_HI.
  - S_HI: read of pc in flight. Register mem_addr=pc+1 (ADDR_W wrap), mem_rd_en=1. Go to S_LO.
  - S_LO: capture mem_rdata into the hi latch. Set mem_rd_en=0. Go to S_CAP.
  - S_CAP: instruction={hi latch, mem_rdata}, instr_valid=1. Go to S_VALID.
  - S_VALID: hold instruction and instr_valid until transfer. On transfer:
    - Compute next PC (see priority rules below).
    - Set instr_valid=0, mem_addr=next PC, mem_rd_en=1. Go to S_HI.
- Latency: 3 cycles from mem_rd_en first asserted for pc to instr_valid=1. Back-to-back rate is 1 instruction per 4 cycles with instr_ready held high.
- Next-PC priority on transfer:
  1. pc_load=1: pc_load_addr (pc_skip ignored).
  2. pc_skip=1: pc+4.
  3. Otherwise: pc+2.
- PC arithmetic is modulo 2^ADDR_W: 12'hFFE+2=12'h000; 12'hFFE+4=12'h002; the lo-byte fetch at 12'hFFF reads 12'h000.
- pc_load and pc_skip are sampled only in the transfer cycle; they are ignored at all other times.
- Odd pc_load_addr is legal; bytes are fetched from addr and addr+1.
- instruction and pc must not change while instr_valid=1. instr_ready is a don't-care when instr_valid=0.
- mem_rdata is ignored in states other than S_LO and S_CAP.

Test Plan:
- Reset, memory holds 0x200=8'h12, 0x201=8'h34, instr_ready=1 -> mem_rd_en at 0x200 then 0x201; instruction=16'h1234, instr_valid=1 exactly 3 cycles after the first mem_rd_en; pc=12'h200.
- Sequential stream 00E0, 6A05, 7A01 at 0x200.. with instr_ready=1 -> transfers every 4 cycles with pc=200, 202, 204.
- Backpressure: instr_ready=0 for 10 cycles with 16'hA2F0 valid -> instruction, pc, and instr_valid stay constant and no mem_rd_en occurs; raising instr_ready gives one transfer.
- Transfer at pc=12'h200 with pc_load=1, pc_load_addr=12'h3A1, pc_skip=1 -> next fetch reads 0x3A1 and 0x3A2; pc=12'h3A1 (load wins over skip).
- Transfer with pc_skip=1 at pc=12'hFFE -> pc=12'h002; separately, pc_load to 12'hFFF -> bytes read from 0xFFF, then 0x000.
- Assert rst for 1 cycle while in S_LO -> next cycle instr_valid=0, pc=12'h200, state restarts from S_START; a stale mem_rdata does not appear in instruction.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: reads two bytes at pc from byte-wide program
// memory, assembles the big-endian opcode and hands it to decode.
// Handshake: a transfer happens in any cycle where instr_valid & instr_ready
// are both 1 at the rising edge. Once instr_valid is 1, instruction and pc
// stay stable until that transfer. instr_ready is ignored while instr_valid=0.
module fetch_unit #(
  parameter int                 ADDR_W   = 12,
  parameter logic [ADDR_W-1:0]  RESET_PC = 12'h200
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [7:0]        mem_rdata,
  output logic [15:0]       instruction,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [ADDR_W-1:0] pc,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_addr,
  input  logic              pc_skip
);

  typedef enum logic [2:0] {
    S_START = 3'd0,
    S_HI    = 3'd1,
    S_LO    = 3'd2,
    S_CAP   = 3'd3,
    S_VALID = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [7:0]        hi_byte, hi_byte_nxt;
  logic [ADDR_W-1:0] pc_nxt, mem_addr_nxt, target_pc;
  logic              mem_rd_en_nxt, instr_valid_nxt;
  logic [15:0]       instruction_nxt;

  // Next PC if a transfer happens this cycle: load beats skip beats +2.
  always_comb begin
    target_pc = pc + ADDR_W'(2);
    if (pc_load) begin
      target_pc = pc_load_addr;
    end else if (pc_skip) begin
      target_pc = pc + ADDR_W'(4);
    end
  end

  // Next-state and next-output logic; every register holds by default.
  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    mem_addr_nxt    = mem_addr;
    mem_rd_en_nxt   = mem_rd_en;
    instruction_nxt = instruction;
    instr_valid_nxt = instr_valid;
    hi_byte_nxt     = hi_byte;
    case (state)
      S_START: begin
        mem_addr_nxt  = pc;
        mem_rd_en_nxt = 1'b1;
        state_nxt     = S_HI;
      end
      S_HI: begin
        mem_addr_nxt  = pc + ADDR_W'(1);
        mem_rd_en_nxt = 1'b1;
        state_nxt     = S_LO;
      end
      S_LO: begin
        hi_byte_nxt   = mem_rdata;
        mem_rd_en_nxt = 1'b0;
        state_nxt     = S_CAP;
      end
      S_CAP: begin
        instruction_nxt = {hi_byte, mem_rdata};
        instr_valid_nxt = 1'b1;
        state_nxt       = S_VALID;
      end
      S_VALID: begin
        if (instr_ready) begin
          pc_nxt          = target_pc;
          mem_addr_nxt    = target_pc;
          mem_rd_en_nxt   = 1'b1;
          instr_valid_nxt = 1'b0;
          state_nxt       = S_HI;
        end
      end
      default: begin
        state_nxt = S_START;
      end
    endcase
  end

  // State and output registers; reset wins over any in-flight fetch or transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_START;
      pc          <= RESET_PC;
      mem_addr    <= RESET_PC;
      mem_rd_en   <= 1'b0;
      instruction <= 16'h0000;
      instr_valid <= 1'b0;
      hi_byte     <= 8'h00;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      mem_addr    <= mem_addr_nxt;
      mem_rd_en   <= mem_rd_en_nxt;
      instruction <= instruction_nxt;
      instr_valid <= instr_valid_nxt;
      hi_byte     <= hi_byte_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: byte memory model with one-cycle read latency,
// instruction-level reference model of the program counter and opcodes.
module tb_fetch_unit;

  localparam int ADDR_W = 12;
  localparam logic [11:0] RESET_PC = 12'h200;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [11:0] mem_addr;
  logic        mem_rd_en;
  logic [7:0]  mem_rdata;
  logic [15:0] instruction;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [11:0] pc;
  logic        pc_load = 1'b0;
  logic [11:0] pc_load_addr = 12'h000;
  logic        pc_skip = 1'b0;

  fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
    .instruction(instruction), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .pc(pc), .pc_load(pc_load), .pc_load_addr(pc_load_addr), .pc_skip(pc_skip)
  );

  // Program memory: data one cycle after a read strobe, garbage otherwise.
  logic [7:0] mem [0:4095];
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
    else           mem_rdata <= 8'($urandom);
  end

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int start_cyc = 0;
  int nxfer = 0;
  bit rd_seen = 0;
  bit prev_hold = 0;
  logic [15:0] prev_instr;
  logic [11:0] prev_pc;
  logic [11:0] exp_pc;
  logic [15:0] exp_q[$];   // opcodes the model expects decode to receive

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Model opcode at an address: big-endian bytes, address wraps mod 4096.
  function automatic logic [15:0] opcode_at(input logic [11:0] a);
    logic [11:0] a1;
    a1 = a + 12'd1;
    return {mem[a], mem[a1]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk); cyc++;
    rst = 1'b0;
    chk("rst_valid", instr_valid, 0);
    chk("rst_pc", pc, RESET_PC);
    chk("rst_instr", instruction, 16'h0000);
    chk("rst_rd_en", mem_rd_en, 0);
    chk("rst_addr", mem_addr, RESET_PC);
    exp_pc = RESET_PC;
    rd_seen = 0;
    prev_hold = 0;
    exp_q.delete();
  endtask

  // Check current outputs against the model, then drive inputs for the next edge.
  task automatic step(input bit rdy, input bit ld, input logic [11:0] la, input bit sk);
    logic [11:0] lo_addr;
    lo_addr = exp_pc + 12'd1;
    if (instr_valid) begin
      if (prev_hold) begin
        chk("hold_instr", instruction, prev_instr);
        chk("hold_pc", pc, prev_pc);
      end else begin
        chk("instr", instruction, opcode_at(exp_pc));
        chk("pc", pc, exp_pc);
        chk("latency", cyc - start_cyc, 3);
      end
      chk("no_rd_while_valid", mem_rd_en, 0);
    end else if (mem_rd_en) begin
      if (!rd_seen) begin
        chk("rd_addr_hi", mem_addr, exp_pc);
        rd_seen = 1;
        start_cyc = cyc;
      end else begin
        chk("rd_addr_lo", mem_addr, lo_addr);
      end
    end
    instr_ready  = rdy;
    pc_load      = ld;
    pc_load_addr = la;
    pc_skip      = sk;
    if (instr_valid && rdy) begin
      exp_q.push_back(opcode_at(exp_pc));
      if (ld)      exp_pc = la;
      else if (sk) exp_pc = exp_pc + 12'd4;
      else         exp_pc = exp_pc + 12'd2;
      rd_seen = 0;
      nxfer++;
    end
    prev_hold  = instr_valid && !rdy;
    prev_instr = instruction;
    prev_pc    = pc;
    @(negedge clk); cyc++;
  endtask

  // Wait (bounded) for a valid instruction, then transfer it with the given controls.
  task automatic xfer(input bit ld, input logic [11:0] la, input bit sk);
    int n;
    n = 0;
    while (!instr_valid && n < 20) begin
      step(0, $urandom_range(0, 1), 12'($urandom), $urandom_range(0, 1));
      n++;
    end
    if (!instr_valid) chk("wait_valid_timeout", 0, 1);
    step(1, ld, la, sk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base;
    foreach (mem[i]) mem[i] = 8'($urandom);

    // First fetch after reset.
    mem[12'h200] = 8'h12; mem[12'h201] = 8'h34;
    do_reset();
    for (int i = 0; i < 6; i++) step(1, 0, 12'h000, 0);
    chk("first_opcode", exp_q.size() > 0 ? exp_q[0] : 16'hxxxx, 16'h1234);

    // Sequential stream at 4 cycles per instruction.
    mem[12'h200] = 8'h00; mem[12'h201] = 8'hE0;
    mem[12'h202] = 8'h6A; mem[12'h203] = 8'h05;
    mem[12'h204] = 8'h7A; mem[12'h205] = 8'h01;
    mem[12'h206] = 8'hA2; mem[12'h207] = 8'hF0;
    do_reset();
    base = nxfer;
    for (int i = 0; i < 13; i++) step(1, 0, 12'h000, 0);
    chk("stream_xfers", nxfer - base, 3);
    chk("stream_pc_next", exp_pc, 12'h206);

    // Backpressure on A2F0, then exactly one transfer.
    base = nxfer;
    for (int i = 0; i < 14; i++) step(0, 1, 12'($urandom), 1);
    chk("bp_valid_held", instr_valid, 1);
    step(1, 0, 12'h000, 0);
    for (int i = 0; i < 2; i++) step(0, 0, 12'h000, 0);
    chk("bp_one_xfer", nxfer - base, 1);
    chk("bp_opcode", exp_q[exp_q.size() - 1], 16'hA2F0);

    // Load beats skip; then wrap cases at the top of memory.
    do_reset();
    xfer(1, 12'h3A1, 1);
    chk("load_wins_pc", exp_pc, 12'h3A1);
    xfer(1, 12'hFFE, 0);
    xfer(0, 12'h000, 1);
    chk("skip_wrap_pc", exp_pc, 12'h002);
    xfer(1, 12'hFFF, 0);
    xfer(0, 12'h000, 0);
    chk("seq_wrap_pc", exp_pc, 12'h001);

    // Reset while the hi byte is being captured.
    xfer(0, 12'h000, 0);
    step(0, 0, 12'h000, 0);
    chk("in_lo_rd_en", mem_rd_en, 1);
    do_reset();
    xfer(0, 12'h000, 0);

    // Randomized run with random memory, backpressure, loads and skips.
    foreach (mem[i]) mem[i] = 8'($urandom);
    do_reset();
    base = nxfer;
    for (int i = 0; i < 3000; i++) begin
      logic [11:0] la;
      case ($urandom_range(0, 3))
        0: la = 12'hFFE;
        1: la = 12'hFFF;
        default: la = 12'($urandom);
      endcase
      step($urandom_range(0, 9) < 7, $urandom_range(0, 4) == 0, la, $urandom_range(0, 2) == 0);
    end
    chk("rand_progress", (nxfer - base) > 300, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
